// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous data-memory port between the core's
// load/store unit and a host loader/debug port.
// Round-robin arbitration, an optional host burst lock, and a starvation guard
// that bounds how many consecutive cycles a CPU request can be denied.
// Optional feature: define ARB_STATS_EN to add saturating grant/conflict counters.
module dmem_arbiter #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  // core load/store port
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  // host loader/debug port
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_lock,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  // memory port
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   cpu_gnt_cnt,
  output logic [15:0]   host_gnt_cnt,
  output logic [15:0]   conflict_cnt
`endif
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  // rr_last encoding: which side was granted most recently
  localparam logic LastCpu  = 1'b0;
  localparam logic LastHost = 1'b1;

  typedef enum logic {StRr, StLock} state_e;

  state_e        state_q, state_d;
  logic          rr_last_q, rr_last_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          cpu_rd_q, host_rd_q;
  logic          force_cpu;
  logic          lock_hold;

  // Starvation limit reached: CPU wins regardless of lock or round-robin order
  assign force_cpu = cpu_req && (wait_q == WW'(MAX_WAIT));
  // Lock only holds while the host keeps both request and lock asserted
  assign lock_hold = (state_q == StLock) && host_req && host_lock;

  // Grant decision plus next-state for lock, round-robin pointer and wait counter
  always_comb begin
    cpu_gnt   = 1'b0;
    host_gnt  = 1'b0;
    if (force_cpu) begin
      cpu_gnt = 1'b1;
    end else if (lock_hold) begin
      host_gnt = 1'b1;
    end else if (cpu_req && host_req) begin
      if (rr_last_q == LastHost) begin
        cpu_gnt = 1'b1;
      end else begin
        host_gnt = 1'b1;
      end
    end else begin
      cpu_gnt  = cpu_req;
      host_gnt = host_req;
    end

    // A locked host grant (from RR or LOCK) keeps/enters LOCK; anything else drops to RR
    state_d = (host_gnt && host_lock) ? StLock : StRr;

    rr_last_d = rr_last_q;
    if (cpu_gnt) begin
      rr_last_d = LastCpu;
    end else if (host_gnt) begin
      rr_last_d = LastHost;
    end

    wait_d = '0;
    if (cpu_req && !cpu_gnt) begin
      wait_d = wait_q + WW'(1);
    end
  end

  // Memory port mux from the winner; idle port drives zeros
  always_comb begin
    mem_en    = cpu_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // Arbitration state and read-owner tag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StRr;
      rr_last_q <= LastHost;
      wait_q    <= '0;
      cpu_rd_q  <= 1'b0;
      host_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      wait_q    <= wait_d;
      cpu_rd_q  <= cpu_gnt && !cpu_we;
      host_rd_q <= host_gnt && !host_we;
    end
  end

  // Read data arrives one cycle after the grant; only the tagged owner sees it
  assign cpu_rvalid  = cpu_rd_q;
  assign host_rvalid = host_rd_q;
  assign cpu_rdata   = cpu_rd_q ? mem_rdata : '0;
  assign host_rdata  = host_rd_q ? mem_rdata : '0;

`ifdef ARB_STATS_EN
  // Saturating usage counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_gnt_cnt  <= '0;
      host_gnt_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      if (cpu_gnt && (cpu_gnt_cnt != 16'hFFFF)) begin
        cpu_gnt_cnt <= cpu_gnt_cnt + 16'd1;
      end
      if (host_gnt && (host_gnt_cnt != 16'hFFFF)) begin
        host_gnt_cnt <= host_gnt_cnt + 16'd1;
      end
      if (cpu_req && host_req && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
